// File: rtl/coram_multibank_sum_kernel_if.sv
`default_nettype none
// ============================================================================
// Module   : coram_multibank_sum_kernel_if
// Brief    : Bank-memory and channel bundle for the multibank sum kernel.
//            The master side is the kernel; the slave side holds the banks
//            and the control-thread channel.
// Revision : 1.0
// ============================================================================
interface coram_multibank_sum_kernel_if #(
  parameter int W_A       = 13,
  parameter int W_D       = 32,
  parameter int NUM_BANKS = 4
);

  // Bank ports, bank b occupies slice [b*W +: W]
  logic [NUM_BANKS*W_A-1:0] mem_addr;
  logic [NUM_BANKS*W_D-1:0] mem_d;
  logic [NUM_BANKS-1:0]     mem_we;
  logic [NUM_BANKS*W_D-1:0] mem_q;

  // Command/result channel
  logic [W_D-1:0]           comm_q;
  logic                     comm_deq;
  logic                     comm_empty;
  logic [W_D-1:0]           comm_d;
  logic                     comm_enq;
  logic                     comm_full;

  modport master (
    output mem_addr, mem_d, mem_we, comm_deq, comm_d, comm_enq,
    input  mem_q, comm_q, comm_empty, comm_full
  );

  modport slave (
    input  mem_addr, mem_d, mem_we, comm_deq, comm_d, comm_enq,
    output mem_q, comm_q, comm_empty, comm_full
  );

endinterface
`default_nettype wire

// File: rtl/coram_multibank_sum_kernel.sv
`default_nettype none
// ============================================================================
// Module   : coram_multibank_sum_kernel
// Brief    : Pops a length from the channel, reads that many words from every
//            bank in lock-step, sums them all and pushes the total back.
//            Length is clipped to the bank depth; optional saturation.
// Revision : 1.0
// ============================================================================
module coram_multibank_sum_kernel #(
  parameter int W_A       = 13,
  parameter int W_D       = 32,
  parameter int NUM_BANKS = 4,
  parameter int SATURATE  = 0
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  coram_multibank_sum_kernel_if.master bus,
  output logic                         busy_o,
  output logic [15:0]                  done_count_o
);

  // Accumulator wide enough that 2**W_A words from every bank never wrap
  localparam int W_ACC = W_D + W_A + $clog2(NUM_BANKS) + 1;
  // Length register holds 0..2**W_A inclusive
  localparam int W_N   = W_A + 1;
  // Comparison width able to hold both a channel word and 2**W_A
  localparam int W_CMP = W_D + W_A + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [W_A-1:0]   addr_q, addr_d;
  logic [W_N-1:0]   len_q, len_d;
  logic [W_ACC-1:0] acc_q, acc_d;
  logic             rd_valid_q, rd_valid_d;
  logic [15:0]      done_q, done_d;

  logic [W_ACC-1:0] bank_sum;
  logic [W_CMP-1:0] cmd_ext;
  logic [W_N-1:0]   cmd_len;
  logic             deq, enq;
  wire logic [W_D-1:0] result;

  // Sum of the current read word across all banks
  always_comb begin
    bank_sum = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_sum = bank_sum + W_ACC'(bus.mem_q[b*W_D +: W_D]);
    end
  end

  // Requested length clipped to the bank depth
  always_comb begin
    cmd_ext = W_CMP'(bus.comm_q);
    if (cmd_ext > (W_CMP'(1) << W_A)) begin
      cmd_len = W_N'(1) << W_A;
    end else begin
      cmd_len = cmd_ext[W_N-1:0];
    end
  end

  // Next-state and handshake logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    acc_d      = acc_q;
    done_d     = done_q;
    deq        = 1'b0;
    enq        = 1'b0;
    // Read data lags the address by one cycle
    rd_valid_d = (state_q == S_READ);
    if (rd_valid_q) begin
      acc_d = acc_q + bank_sum;
    end

    case (state_q)
      S_IDLE: begin
        if (!bus.comm_empty && !rst) begin
          deq   = 1'b1;
          len_d = cmd_len;
          acc_d = '0;
          if (cmd_len == '0) begin
            state_d = S_SEND;
          end else begin
            addr_d  = '0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (W_N'(addr_q) == (len_q - W_N'(1))) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + W_A'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!bus.comm_full && !rst) begin
          enq     = 1'b1;
          done_d  = done_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  generate
    if (SATURATE != 0) begin : g_sat_on
      assign result = (acc_q > W_ACC'({W_D{1'b1}})) ? {W_D{1'b1}} : acc_q[W_D-1:0];
    end else begin : g_sat_off
      assign result = acc_q[W_D-1:0];
    end
  endgenerate

  assign bus.mem_addr  = {NUM_BANKS{addr_q}};
  assign bus.mem_d     = '0;
  assign bus.mem_we    = '0;
  assign bus.comm_deq  = deq;
  assign bus.comm_enq  = enq;
  assign bus.comm_d    = result;
  assign busy_o        = (state_q != S_IDLE);
  assign done_count_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_coram_multibank_sum_kernel.sv
`default_nettype none
// ============================================================================
// Module   : tb_coram_multibank_sum_kernel
// Brief    : Self-checking bench; two kernels (wrapping and saturating) run
//            the same commands against a shared bank image.
// Revision : 1.0
// ============================================================================
module tb_coram_multibank_sum_kernel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coram_multibank_sum_kernel_if #(.W_A(4), .W_D(32), .NUM_BANKS(4)) ia ();
  coram_multibank_sum_kernel_if #(.W_A(4), .W_D(32), .NUM_BANKS(4)) ib ();

  logic        busy0, busy1;
  logic [15:0] done0, done1;

  coram_multibank_sum_kernel #(.W_A(4), .W_D(32), .NUM_BANKS(4), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(ia), .busy_o(busy0), .done_count_o(done0));
  coram_multibank_sum_kernel #(.W_A(4), .W_D(32), .NUM_BANKS(4), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(ib), .busy_o(busy1), .done_count_o(done1));

  // Bank contents: mem[bank][word]
  logic [31:0] mem [4][16];

  // Banks with one-cycle read latency
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      ia.mem_q[b*32 +: 32] <= mem[b][ia.mem_addr[b*4 +: 4]];
      ib.mem_q[b*32 +: 32] <= mem[b][ib.mem_addr[b*4 +: 4]];
    end
  end

  int errors = 0;
  int checks = 0;
  int exp_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++)
        case (pat)
          0:       mem[b][i] = 32'(i + b);
          1:       mem[b][i] = 32'hFFFF_FFFF;
          default: mem[b][i] = $urandom;
        endcase
  endtask

  // Reference: total of the first min(cmd,16) words of every bank
  function automatic logic [63:0] model_sum(input logic [31:0] cmd);
    logic [63:0] s = 64'd0;
    int n = (cmd > 32'd16) ? 16 : int'(cmd);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++)
        s += 64'(mem[b][i]);
    return s;
  endfunction

  function automatic logic [31:0] sat32(input logic [63:0] s);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // One command: called and returns at a negedge
  task automatic run_cmd(input logic [31:0] cmd, input int full_cyc, input int exp_lat,
                         input logic [31:0] exp_d0, input logic [31:0] exp_d1);
    int n, cyc, enq_cyc;
    logic addr_ok, hold_ok, proto_ok;
    logic [15:0] prev_addr;
    logic [3:0]  ea;
    n = (cmd > 32'd16) ? 16 : int'(cmd);
    ia.comm_q = cmd; ib.comm_q = cmd;
    ia.comm_empty = 1'b0; ib.comm_empty = 1'b0;
    ia.comm_full = (full_cyc > 0); ib.comm_full = (full_cyc > 0);
    prev_addr = ia.mem_addr;
    #1;
    chk("deq", {62'd0, ia.comm_deq, ib.comm_deq}, 64'd3);
    @(negedge clk);
    ia.comm_empty = 1'b1; ib.comm_empty = 1'b1;
    cyc = 1; enq_cyc = -1;
    addr_ok = 1'b1; hold_ok = 1'b1; proto_ok = 1'b1;
    while (cyc < 100 && enq_cyc < 0) begin
      if (cyc == exp_lat + full_cyc) begin
        ia.comm_full = 1'b0; ib.comm_full = 1'b0;
      end
      #1;
      if (n > 0 && cyc <= n) begin
        ea = 4'(cyc - 1);
        if (ia.mem_addr !== {4{ea}} || ib.mem_addr !== {4{ea}}) addr_ok = 1'b0;
      end
      if (n == 0 && ia.mem_addr !== prev_addr) addr_ok = 1'b0;
      if (ia.comm_deq || ib.comm_deq || !busy0 || !busy1) proto_ok = 1'b0;
      if (ia.comm_enq !== ib.comm_enq || ia.mem_we !== 4'd0 || ia.mem_d !== '0) proto_ok = 1'b0;
      if (cyc >= exp_lat && cyc < exp_lat + full_cyc) begin
        if (ia.comm_enq || ia.comm_d !== exp_d0 || ib.comm_d !== exp_d1) hold_ok = 1'b0;
      end
      if (ia.comm_enq === 1'b1) begin
        enq_cyc = cyc;
        chk("comm_d_wrap", 64'(ia.comm_d), 64'(exp_d0));
        chk("comm_d_sat",  64'(ib.comm_d), 64'(exp_d1));
      end
      @(negedge clk);
      cyc++;
    end
    chk("enq_cycle", 64'(enq_cyc), 64'(exp_lat + full_cyc));
    chk("addr_seq", 64'(addr_ok), 64'd1);
    chk("protocol", 64'(proto_ok), 64'd1);
    if (full_cyc > 0) chk("full_hold", 64'(hold_ok), 64'd1);
    exp_done++;
    ia.comm_full = 1'b0; ib.comm_full = 1'b0;
    #1;
    chk("done_count", {32'd0, done0, done1}, {32'd0, 16'(exp_done), 16'(exp_done)});
    chk("idle_after", {62'd0, busy0, busy1}, 64'd0);
    @(negedge clk);
  endtask

  typedef struct {
    int          pat;
    logic [31:0] cmd;
    int          full_cyc;
    int          lat;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [63:0] s;
    logic [31:0] cmd;
    int n, full, cnt;

    vecs[0] = '{0, 32'd8,          0, 10, 32'd160,        32'd160};
    vecs[1] = '{0, 32'd0,          0, 1,  32'd0,          32'd0};
    vecs[2] = '{1, 32'd4,          0, 6,  32'hFFFF_FFF0,  32'hFFFF_FFFF};
    vecs[3] = '{0, 32'hFFFF_FFFF,  0, 18, 32'd576,        32'd576};
    vecs[4] = '{0, 32'd3,          5, 5,  32'd30,         32'd30};
    vecs[5] = '{0, 32'd16,         0, 18, 32'd576,        32'd576};
    vecs[6] = '{0, 32'd17,         2, 18, 32'd576,        32'd576};

    ia.comm_q = '0; ib.comm_q = '0;
    ia.comm_empty = 1'b1; ib.comm_empty = 1'b1;
    ia.comm_full = 1'b0; ib.comm_full = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", {62'd0, busy0, busy1}, 64'd0);
    chk("rst_done", {32'd0, done0, done1}, 64'd0);
    chk("rst_hs", {60'd0, ia.comm_deq, ia.comm_enq, ib.comm_deq, ib.comm_enq}, 64'd0);
    chk("rst_d", {ia.comm_d, ib.comm_d}, 64'd0);
    chk("rst_addr", {32'd0, ia.mem_addr, ib.mem_addr}, 64'd0);
    @(negedge clk);

    // Directed table
    for (int k = 0; k < 7; k++) begin
      fill(vecs[k].pat);
      run_cmd(vecs[k].cmd, vecs[k].full_cyc, vecs[k].lat, vecs[k].d0, vecs[k].d1);
    end

    // Random data and lengths against the reference model
    for (int k = 0; k < 12; k++) begin
      fill(2);
      cmd  = (k % 4 == 0) ? $urandom : 32'($urandom_range(0, 20));
      full = $urandom_range(0, 3);
      n    = (cmd > 32'd16) ? 16 : int'(cmd);
      s    = model_sum(cmd);
      run_cmd(cmd, full, (n == 0) ? 1 : n + 2, s[31:0], sat32(s));
    end

    // Reset in the middle of a read burst
    fill(2);
    ia.comm_q = 32'd10; ib.comm_q = 32'd10;
    ia.comm_empty = 1'b0; ib.comm_empty = 1'b0;
    @(negedge clk);
    ia.comm_empty = 1'b1; ib.comm_empty = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_busy", {62'd0, busy0, busy1}, 64'd0);
    chk("midrst_done", {32'd0, done0, done1}, 64'd0);
    chk("midrst_hs", {60'd0, ia.comm_deq, ia.comm_enq, ib.comm_deq, ib.comm_enq}, 64'd0);
    chk("midrst_d", {ia.comm_d, ib.comm_d}, 64'd0);
    chk("midrst_addr", {32'd0, ia.mem_addr, ib.mem_addr}, 64'd0);
    rst = 1'b0;
    exp_done = 0;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (ia.comm_enq || ib.comm_enq || busy0 || busy1) cnt++;
    end
    chk("midrst_quiet", 64'(cnt), 64'd0);
    @(negedge clk);
    s = model_sum(32'd2);
    run_cmd(32'd2, 0, 4, s[31:0], sat32(s));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
